// File: rtl/pulse2_ctrl_if.sv
// CPU-side register bus for pulse channel 2: write port plus combinational read-back.
interface pulse2_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/pulse2_ctrl.sv
// Pulse channel 2 register front-end and frame sequencer.
// Decodes NR21..NR24 writes into channel fields, derives the 256/128/64 Hz
// sequencer clocks from clk, and holds the trigger level until every
// sequencer clock has produced a rising edge while it was high.
//
// Trigger FSM:
//   state    | meaning
//   ST_IDLE  | trigger low, seen flags ignored
//   ST_ARMED | trigger high, collecting 256/128/64 Hz rising edges
module pulse2_ctrl #(
  parameter int CLK_DIV = 8192
) (
  input  logic              clk,
  input  logic              rst,
  pulse2_ctrl_if.slave      bus,
  output logic              o_clk_256,
  output logic              o_clk_128,
  output logic              o_clk_64,
  output logic [10:0]       o_freq,
  output logic [5:0]        o_length_load,
  output logic [1:0]        o_duty_cycle,
  output logic [3:0]        o_starting_volume,
  output logic [2:0]        o_period,
  output logic              o_env_add,
  output logic              o_length_enable,
  output logic              o_trigger
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] A_NR21 = 2'd0;
  localparam logic [1:0] A_NR22 = 2'd1;
  localparam logic [1:0] A_NR23 = 2'd2;
  localparam logic [1:0] A_NR24 = 2'd3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_step;
  logic [0:0]       r_state;
  logic [2:0]       r_seen;   // {s64, s128, s256}

  logic [10:0] r_freq;
  logic [5:0]  r_length_load;
  logic [1:0]  r_duty_cycle;
  logic [3:0]  r_starting_volume;
  logic [2:0]  r_period;
  logic        r_env_add;
  logic        r_length_enable;

  logic       w_wrap;
  logic       w_rise_256;
  logic       w_rise_128;
  logic       w_rise_64;
  logic       w_arm;
  logic [7:0] w_rd_data;

  // Rising edges are known one edge early from the step about to increment,
  // so they line up with the edge where the sequencer clock actually goes high.
  always_comb begin
    w_wrap     = (r_div == DIV_MAX);
    w_rise_256 = w_wrap && !r_step[0];
    w_rise_128 = w_wrap && (r_step[1:0] == 2'b01);
    w_rise_64  = w_wrap && (r_step == 3'b011);
    w_arm      = bus.wr_en && (bus.wr_addr == A_NR24) && bus.wr_data[7];
  end

  // Frame sequencer: divider wraps at CLK_DIV-1 and advances the 3-bit step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_step <= '0;
    end else if (w_wrap) begin
      r_div  <= '0;
      r_step <= r_step + 3'd1;
    end else begin
      r_div  <= r_div + DIV_W'(1);
    end
  end

  // Register file: every write is accepted, last write wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_freq            <= '0;
      r_length_load     <= '0;
      r_duty_cycle      <= '0;
      r_starting_volume <= '0;
      r_period          <= '0;
      r_env_add         <= 1'b0;
      r_length_enable   <= 1'b0;
    end else if (bus.wr_en) begin
      case (bus.wr_addr)
        A_NR21: begin
          r_duty_cycle  <= bus.wr_data[7:6];
          r_length_load <= bus.wr_data[5:0];
        end
        A_NR22: begin
          r_starting_volume <= bus.wr_data[7:4];
          r_env_add         <= bus.wr_data[3];
          r_period          <= bus.wr_data[2:0];
        end
        A_NR23: begin
          r_freq[7:0] <= bus.wr_data;
        end
        default: begin
          r_length_enable <= bus.wr_data[6];
          r_freq[10:8]    <= bus.wr_data[2:0];
        end
      endcase
    end
  end

  // Trigger hold: arming clears the flags, so a rise on the arming edge never
  // counts; release happens one edge after all three flags are set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_seen  <= '0;
    end else if (w_arm) begin
      r_state <= ST_ARMED;
      r_seen  <= '0;
    end else if (r_state == ST_ARMED) begin
      if (&r_seen) begin
        r_state <= ST_IDLE;
      end else begin
        r_seen <= r_seen | {w_rise_64, w_rise_128, w_rise_256};
      end
    end
  end

  // Read-back with write-only bits returning 1.
  always_comb begin
    w_rd_data = 8'hFF;
    case (bus.rd_addr)
      A_NR21:  w_rd_data = {r_duty_cycle, 6'h3F};
      A_NR22:  w_rd_data = {r_starting_volume, r_env_add, r_period};
      A_NR23:  w_rd_data = 8'hFF;
      default: w_rd_data = {1'b1, r_length_enable, 6'h3F};
    endcase
  end

  assign bus.rd_data       = w_rd_data;
  assign o_clk_256         = r_step[0];
  assign o_clk_128         = r_step[1];
  assign o_clk_64          = r_step[2];
  assign o_freq            = r_freq;
  assign o_length_load     = r_length_load;
  assign o_duty_cycle      = r_duty_cycle;
  assign o_starting_volume = r_starting_volume;
  assign o_period          = r_period;
  assign o_env_add         = r_env_add;
  assign o_length_enable   = r_length_enable;
  assign o_trigger         = (r_state == ST_ARMED);

endmodule

// File: tb/tb_pulse2_ctrl.sv
// Directed bench for pulse2_ctrl with CLK_DIV=4; edge numbers count clk
// edges since the last reset release.
module tb_pulse2_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        clk_256, clk_128, clk_64;
  logic [10:0] freq;
  logic [5:0]  length_load;
  logic [1:0]  duty_cycle;
  logic [3:0]  starting_volume;
  logic [2:0]  period;
  logic        env_add, length_enable, trigger;

  int checks   = 0;
  int failures = 0;
  int ecount   = 0;

  pulse2_ctrl_if bus ();

  pulse2_ctrl #(.CLK_DIV(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus.slave),
    .o_clk_256         (clk_256),
    .o_clk_128         (clk_128),
    .o_clk_64          (clk_64),
    .o_freq            (freq),
    .o_length_load     (length_load),
    .o_duty_cycle      (duty_cycle),
    .o_starting_volume (starting_volume),
    .o_period          (period),
    .o_env_add         (env_add),
    .o_length_enable   (length_enable),
    .o_trigger         (trigger)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) ecount = 0;
    else     ecount = ecount + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_to(input int e);
    int guard;
    guard = 0;
    while (ecount < e && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (ecount < e) chk("run_to_timeout", 16'(ecount), 16'(e));
  endtask

  task automatic write_at(input int e, input logic [1:0] a, input logic [7:0] d);
    run_to(e - 1);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    run_to(e);
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    bus.rd_addr = a;
    #1;
    chk(tag, 16'(bus.rd_data), 16'(exp));
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = 2'd0;
    bus.wr_data = 8'h00;
    bus.rd_addr = 2'd0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trigger", 16'(trigger), 16'h0);
    chk("rst_clks", 16'({clk_256, clk_128, clk_64}), 16'h0);
    chk("rst_freq", 16'(freq), 16'h0);
    chk("rst_fields", 16'({duty_cycle, length_load, starting_volume, env_add, period, length_enable}), 16'h0);
    rd("rst_rd_nr24", 2'd3, 8'hBF);
    rd("rst_rd_nr23", 2'd2, 8'hFF);
    rd("rst_rd_nr21", 2'd0, 8'h3F);
    rd("rst_rd_nr22", 2'd1, 8'h00);

    rst = 1'b0;

    // register writes on edges 1..4
    write_at(1, 2'd0, 8'hC5);
    chk("nr21_duty_next_cycle", 16'(duty_cycle), 16'd3);
    write_at(2, 2'd1, 8'hA3);
    write_at(3, 2'd2, 8'h34);
    write_at(4, 2'd3, 8'h45);
    chk("duty_cycle", 16'(duty_cycle), 16'd3);
    chk("length_load", 16'(length_load), 16'd5);
    chk("starting_volume", 16'(starting_volume), 16'd10);
    chk("env_add", 16'(env_add), 16'd0);
    chk("period", 16'(period), 16'd3);
    chk("freq", 16'(freq), 16'h534);
    chk("length_enable", 16'(length_enable), 16'd1);
    chk("no_trigger_d7_0", 16'(trigger), 16'd0);
    rd("rd_nr21", 2'd0, 8'hFF);
    rd("rd_nr22", 2'd1, 8'hA3);
    rd("rd_nr24", 2'd3, 8'hFF);

    // free-running sequencer clocks
    chk("e4_clk256", 16'(clk_256), 16'd1);
    run_to(7);
    chk("e7_clks", 16'({clk_64, clk_128, clk_256}), 16'b001);
    run_to(8);
    chk("e8_clks", 16'({clk_64, clk_128, clk_256}), 16'b010);
    run_to(12);
    chk("e12_clks", 16'({clk_64, clk_128, clk_256}), 16'b011);
    run_to(15);
    chk("e15_clk64", 16'(clk_64), 16'd0);
    run_to(16);
    chk("e16_clks", 16'({clk_64, clk_128, clk_256}), 16'b100);

    // arm at step 4; release one edge after clk_64 rises at edge 48
    write_at(17, 2'd3, 8'h80);
    chk("arm_trigger", 16'(trigger), 16'd1);
    chk("arm_fields", 16'({length_enable, freq}), 16'h034);
    run_to(20);
    chk("e20_after_256_rise", 16'(trigger), 16'd1);
    run_to(25);
    chk("e25_after_128_rise", 16'(trigger), 16'd1);
    run_to(47);
    chk("e47_hold", 16'(trigger), 16'd1);
    run_to(48);
    chk("e48_clk64_rise", 16'({clk_64, trigger}), 16'b11);
    run_to(49);
    chk("e49_release", 16'(trigger), 16'd0);

    // re-arm, then re-trigger on edge 80 (one before the release edge)
    write_at(50, 2'd3, 8'h80);
    chk("rearm", 16'(trigger), 16'd1);
    write_at(80, 2'd3, 8'h80);
    run_to(81);
    chk("retrig_held_e81", 16'(trigger), 16'd1);
    write_at(90, 2'd3, 8'h00);
    chk("nr24_d7_0_hold", 16'(trigger), 16'd1);
    chk("nr24_d7_0_fields", 16'({length_enable, freq}), 16'h034);
    run_to(112);
    chk("retrig_e112", 16'(trigger), 16'd1);
    run_to(113);
    chk("retrig_release_e113", 16'(trigger), 16'd0);

    // reset in the middle of a hold
    write_at(115, 2'd3, 8'h80);
    run_to(118);
    chk("pre_rst_hold", 16'(trigger), 16'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_trigger", 16'(trigger), 16'd0);
    chk("midrst_clks", 16'({clk_64, clk_128, clk_256}), 16'd0);
    chk("midrst_freq", 16'(freq), 16'd0);
    chk("midrst_duty_vol", 16'({duty_cycle, starting_volume}), 16'd0);
    rd("midrst_rd_nr22", 2'd1, 8'h00);
    rst = 1'b0;
    run_to(3);
    chk("post_rst_e3_clk256", 16'(clk_256), 16'd0);
    run_to(4);
    chk("post_rst_e4_clk256", 16'(clk_256), 16'd1);
    chk("post_rst_trigger", 16'(trigger), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse2_ctrl.md
# pulse2_ctrl

Register front-end and frame sequencer for pulse channel 2. Decodes CPU writes to the four channel-2 registers (NR21–NR24) into the channel's configuration fields. Generates the 256/128/64 Hz sequencer clocks from the system clock. Produces a trigger level that is held until every sequencer clock has sampled it. Sits between the CPU bus and the pulse channel; all outputs connect to the channel's like-named inputs.

## Interface
- CLK_DIV, default 8192: `clk` cycles per 512 Hz sequencer step. Must be ≥ 2. The counter width is clog2(CLK_DIV).
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe; one write per cycle it is high.
- wr_addr  in  2  register select: 0=NR21, 1=NR22, 2=NR23, 3=NR24.
- wr_data  in  8  write data.
- rd_addr  in  2  read select, same encoding as wr_addr.
- rd_data  out  8  combinational read-back with unused bits forced to 1.
- clk_256  out  1  256 Hz square wave, registered.
- clk_128  out  1  128 Hz square wave, registered.
- clk_64  out  1  64 Hz square wave, registered.
- freq  out  11  channel frequency code.
- length_load  out  6  length load value.
- duty_cycle  out  2  duty select.
- starting_volume  out  4  envelope initial volume.
- period  out  3  envelope period.
- env_add  out  1  envelope direction; 1 = increase.
- length_enable  out  1  length counter enable.
- trigger  out  1  registered trigger level, held as described below.

## Operation
- Register writes take effect on the clk edge where wr_en=1:
  - NR21: duty_cycle ← d[7:6]; length_load ← d[5:0].
  - NR22: starting_volume ← d[7:4]; env_add ← d[3]; period ← d[2:0].
  - NR23: freq[7:0] ← d.
  - NR24: length_enable ← d[6]; freq[10:8] ← d[2:0]; d[7] arms a trigger. Bits d[5:3] are ignored.
- Read-back masks (rd_data):
  - NR21 reads {duty_cycle, 6'h3F}.
  - NR22 reads the full stored byte.
  - NR23 reads 8'hFF.
  - NR24 reads {1, length_enable, 6'h3F}.
- Frame sequencer:
  - div counter runs 0..CLK_DIV-1. On wrap, the 3-bit step counter increments, wrapping 7→0.
  - clk_256 = step[0], clk_128 = step[1], clk_64 = step[2], all registered from step.
  - Rising edges: clk_256 on even→odd step; clk_128 on 1→2 and 5→6; clk_64 on 3→4.
- Trigger state, with seen flags s256, s128, s64:
  - IDLE: trigger=0.
  - NR24 write with d[7]=1: at that edge, trigger ← 1 and all seen flags ← 0 (ARMED).
  - ARMED: at each edge where trigger=1 before the edge and clk_x goes 0→1, set s_x.
  - At an edge where all three flags were already 1 before the edge, trigger ← 0 (IDLE).
  - Net effect: trigger falls exactly one clk after the last required rising edge, never on the same edge.
- Re-trigger while ARMED (NR24 with d[7]=1): clears all flags and keeps trigger=1; the hold restarts.
- NR24 write with d[7]=0 while ARMED: updates the fields only; the trigger hold continues.
- Write on the same edge as a sequencer rising edge: that edge does not count toward the new arming, because trigger was 0 (or being re-armed) before the edge.

## Timing
- Reset: every output register, div, step and the seen flags go to 0. trigger=0; clk_256, clk_128 and clk_64 are 0.
- rd_data is combinational from rd_addr after reset; for example, NR24 reads 8'hBF.
- rst asserted mid-hold: trigger drops on that edge, flags clear, and the sequencer restarts from step 0 with div 0.
- Write latency: the field output is valid the cycle after the wr_en edge. Reads are zero-latency.
- Step period is CLK_DIV cycles. The first step increment after reset occurs at cycle CLK_DIV.
- Worst-case trigger hold is 8·CLK_DIV + 1 cycles.
- No backpressure: every wr_en is accepted, and back-to-back writes to the same register keep the last value.

## Test plan
- Reset with CLK_DIV=4 → all outputs 0; rd_data on NR24 = 8'hBF, on NR23 = 8'hFF, on NR21 = 8'h3F.
- Writes NR21=8'hC5, NR22=8'hA3, NR23=8'h34, NR24=8'h45 → duty_cycle=3, length_load=5, starting_volume=10, env_add=0, period=3, freq=11'h534, length_enable=1, trigger=0; NR21 reads 8'hFF.
- Free run, CLK_DIV=4 → clk_256 period 8 cycles, clk_128 period 16 cycles, clk_64 period 32 cycles; clk_64 rises at cycle 16 after reset.
- NR24=8'h80 written at step 4 → trigger high until one cycle after the clk_64 rise at the next 3→4 transition; clk_256 and clk_128 rises occur earlier and do not release it.
- Re-trigger written one cycle before the release edge → trigger stays high and the hold restarts; NR24=8'h00 mid-hold → hold unaffected.
- rst pulsed during a hold → trigger 0 the cycle after, step and clocks at 0, registers cleared.
